// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port between the fetch stage (master) and memory (slave).
// Handshake: master raises req with a stable addr and holds both until the slave
// answers with a single-cycle rvalid carrying rdata; rvalid outside a request is ignored.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux: JR over J/JAL over taken branch over fall-through.
module fetch_unit_next_pc_sel #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
  output logic [ADDR_W-1:0] next_pc,
  output logic              jr_misaligned
);

  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] jump_target;

  always_comb begin
    branch_off    = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};
    // J/JAL keeps the upper region bits of the delay-slot-free pc_plus4.
    jump_target   = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
    jr_misaligned = jump_reg && (jr_target[1:0] != 2'b00);
    next_pc       = pc_plus4;
    if (jump_reg) begin
      next_pc = {jr_target[ADDR_W-1:2], 2'b00};
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, redirects on advance.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  input  logic               advance,
  input  logic               jump,
  input  logic               jump_reg,
  input  logic [25:0]        jump_index,
  input  logic [ADDR_W-1:0]  jr_target,
  input  logic               branch_taken,
  input  logic [15:0]        branch_imm,
  output logic               misalign_err,
  output logic [31:0]        fetch_count,
  output fetch_state_e       dbg_state
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              req_q, req_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic [ADDR_W-1:0] next_pc;
  logic              jr_misaligned;

  fetch_unit_next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .branch_taken  (branch_taken),
    .branch_imm    (branch_imm),
    .next_pc       (next_pc),
    .jr_misaligned (jr_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    req_d         = req_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IDLE: begin
        req_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (imem.rvalid) begin
          instr_d       = imem.rdata;
          instr_valid_d = 1'b1;
          req_d         = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        // Redirect inputs only matter on this edge; the decoder sees NOP while fetching.
        if (advance) begin
          pc_d          = next_pc;
          instr_d       = NOP;
          instr_valid_d = 1'b0;
          req_d         = 1'b1;
          misalign_d    = misalign_q | jr_misaligned;
          state_d       = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      req_q         <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      req_q         <= req_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem.req     = req_q;
  assign imem.addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + ADDR_W'(4);
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder, advance driver, address scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  instr;
  logic         instr_valid;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         advance;
  logic         jump;
  logic         jump_reg;
  logic [25:0]  jump_index;
  logic [31:0]  jr_target;
  logic         branch_taken;
  logic [15:0]  branch_imm;
  logic         misalign_err;
  logic [31:0]  fetch_count;
  fetch_state_e dbg_state;

  int          n_checks   = 0;
  int          n_failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_count;
  logic [31:0] cur_pc;
  logic [31:0] last_instr;

  fetch_unit_if #(.ADDR_W(32)) imem ();

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0040_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .advance      (advance),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count),
    .dbg_state    (dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_redirects();
    advance      = 1'b0;
    jump         = 1'b0;
    jump_reg     = 1'b0;
    jump_index   = 26'd0;
    jr_target    = 32'd0;
    branch_taken = 1'b0;
    branch_imm   = 16'd0;
  endtask

  // Memory driver: wait for the request, answer after lat cycles, check capture.
  task automatic do_fetch(input logic [31:0] data, input int lat);
    int          n = 0;
    logic [31:0] exp_addr;
    while (imem.req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", {31'd0, imem.req}, 32'd1);
    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check_eq("fetch_addr", imem.addr, exp_addr);
    check_eq("pc_during_fetch", pc, exp_addr);
    repeat (lat) @(negedge clk);
    check_eq("valid_before_rvalid", {31'd0, instr_valid}, 32'd0);
    imem.rvalid = 1'b1;
    imem.rdata  = data;
    @(negedge clk);
    imem.rvalid = 1'b0;
    imem.rdata  = 32'd0;
    exp_count   = exp_count + 32'd1;
    last_instr  = data;
    check_eq("instr", instr, data);
    check_eq("instr_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("req_dropped", {31'd0, imem.req}, 32'd0);
    check_eq("fetch_count", fetch_count, exp_count);
    check_eq("state_hold", 32'(dbg_state), 32'(HOLD));
  endtask

  // Advance driver: one-cycle advance pulse with redirect inputs.
  task automatic do_advance(input logic j, input logic jr, input logic bt,
                            input logic [25:0] idx, input logic [31:0] jrt,
                            input logic [15:0] imm, input logic [31:0] exp_next);
    check_eq("pc_plus4", pc_plus4, cur_pc + 32'd4);
    advance      = 1'b1;
    jump         = j;
    jump_reg     = jr;
    branch_taken = bt;
    jump_index   = idx;
    jr_target    = jrt;
    branch_imm   = imm;
    @(negedge clk);
    clear_redirects();
    check_eq("instr_nop", instr, 32'd0);
    check_eq("valid_low", {31'd0, instr_valid}, 32'd0);
    check_eq("req_high", {31'd0, imem.req}, 32'd1);
    exp_q.push_back(exp_next);
    cur_pc = exp_next;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'd0;
    clear_redirects();
    exp_count   = 32'd0;
    last_instr  = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_pc", pc, 32'h0040_0000);
    check_eq("rst_req", {31'd0, imem.req}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check_eq("rst_count", fetch_count, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));

    rst_n  = 1'b1;
    cur_pc = 32'h0040_0000;
    exp_q.push_back(32'h0040_0000);
    @(negedge clk);
    check_eq("first_req_cycle1", {31'd0, imem.req}, 32'd1);
    do_fetch(32'h2008_0005, 2);

    // Sequential fetches
    do_advance(1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 16'd0, 32'h0040_0004);
    do_fetch(32'h1111_0001, 0);
    do_advance(1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 16'd0, 32'h0040_0008);
    do_fetch(32'h1111_0002, 1);
    do_advance(1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 16'd0, 32'h0040_000C);
    do_fetch(32'h1111_0003, 3);
    do_advance(1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 16'd0, 32'h0040_0010);
    do_fetch(32'h1000_FFFE, 1);

    // Backward branch: 0x00400014 - 8
    do_advance(1'b0, 1'b0, 1'b1, 26'd0, 32'd0, 16'hFFFE, 32'h0040_000C);
    do_fetch(32'h2222_0001, 2);
    // Jump beats a taken branch
    do_advance(1'b1, 1'b0, 1'b1, 26'h010_0040, 32'd0, 16'hFFFE, 32'h0040_0100);
    do_fetch(32'h0810_0040, 1);
    // JR beats jump; misaligned target is truncated and flagged
    do_advance(1'b1, 1'b1, 1'b0, 26'h010_0040, 32'h0040_0203, 16'd0, 32'h0040_0200);
    check_eq("misalign_set", {31'd0, misalign_err}, 32'd1);
    do_fetch(32'h0300_0008, 1);
    check_eq("misalign_sticky", {31'd0, misalign_err}, 32'd1);

    // Stray rvalid in HOLD must be ignored
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.rvalid = 1'b0;
    imem.rdata  = 32'd0;
    check_eq("hold_instr_kept", instr, last_instr);
    check_eq("hold_count_kept", fetch_count, exp_count);
    check_eq("hold_pc_kept", pc, cur_pc);
    check_eq("hold_state", 32'(dbg_state), 32'(HOLD));

    // Advance in WAIT must be ignored
    do_advance(1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 16'd0, 32'h0040_0204);
    advance    = 1'b1;
    jump       = 1'b1;
    jump_index = 26'h3FF_FFFF;
    @(negedge clk);
    clear_redirects();
    check_eq("wait_pc_kept", pc, 32'h0040_0204);
    check_eq("wait_count_kept", fetch_count, exp_count);
    check_eq("wait_state", 32'(dbg_state), 32'(WAIT));
    do_fetch(32'h3333_0001, 1);
    check_eq("misalign_still", {31'd0, misalign_err}, 32'd1);

    // Wrap from top of address space
    do_advance(1'b0, 1'b1, 1'b0, 26'd0, 32'hFFFF_FFFC, 16'd0, 32'hFFFF_FFFC);
    do_fetch(32'h4444_0001, 1);
    check_eq("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    do_advance(1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 16'd0, 32'h0000_0000);
    do_fetch(32'h4444_0002, 2);

    // Reset while a request is outstanding
    do_advance(1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 16'd0, 32'h0000_0004);
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_pc", pc, 32'h0040_0000);
    check_eq("mid_rst_req", {31'd0, imem.req}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("mid_rst_misalign", {31'd0, misalign_err}, 32'd0);
    check_eq("mid_rst_count", fetch_count, 32'd0);
    rst_n     = 1'b1;
    exp_count = 32'd0;
    cur_pc    = 32'h0040_0000;
    exp_q.push_back(32'h0040_0000);
    do_fetch(32'h5555_0001, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder (control). It owns the program counter and issues one word fetch at a time to instruction memory over a req/rvalid handshake. It presents the fetched word on instr, which the decoder decodes combinationally. On an advance pulse from the core it computes the next PC from the decoder's Jump/JR/Branch outcome. There are no delay slots.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset (MIPS text base)
ADDR_W, 32, PC and imem_addr width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
imem_req  out  1  fetch request; held high until response
imem_addr  out  ADDR_W  word-aligned fetch address (equals pc)
imem_rvalid  in  1  response strobe, one cycle
imem_rdata  in  32  fetched instruction, valid with imem_rvalid
instr  out  32  instruction to decoder; 32'h0 when instr_valid=0
instr_valid  out  1  instr holds a fetched word for pc
pc  out  ADDR_W  address of current instr
pc_plus4  out  ADDR_W  pc + 4, for JAL link and branch base
advance  in  1  core retires current instr; meaningful only while instr_valid
jump  in  1  J/JAL taken
jump_reg  in  1  JR taken
jump_index  in  26  instr[25:0] target field
jr_target  in  ADDR_W  rs register value
branch_taken  in  1  Branch and condition met
branch_imm  in  16  instr[15:0] offset
misalign_err  out  1  sticky: a JR target had nonzero bits [1:0]
fetch_count  out  32  completed fetches since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values, applied on any edge with rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, misalign_err=0, fetch_count=0.
- Reset mid-operation abandons any outstanding request. Memory is reset on the same rst_n, so no stale response is expected. Any imem_rvalid seen in IDLE is ignored.
- FSM state IDLE: next edge sets imem_req=1 and moves to WAIT. The first request is asserted in cycle 1 after reset release.
- FSM state WAIT: imem_req=1, imem_addr=pc.
  - On imem_rvalid: instr<=imem_rdata, instr_valid<=1, imem_req<=0, fetch_count+=1 (wraps at 2^32), move to HOLD.
  - Minimum request-to-instr_valid latency is 1 cycle after rvalid. Waiting is unbounded.
- FSM state HOLD: instr and pc are stable. imem_rvalid is ignored.
  - On advance: pc<=next_pc, instr_valid<=0, instr<=0, imem_req<=1, move to WAIT.
  - The decoder therefore sees a NOP (0) while fetching. It performs no decode because instr==0.
- advance in IDLE or WAIT has no effect. Redirect inputs are sampled only on the advance edge.
- next_pc priority, highest first:
  1. jump_reg: {jr_target[31:2],2'b00}. Sets misalign_err if jr_target[1:0]!=0.
  2. jump: {pc_plus4[31:28], jump_index, 2'b00}.
  3. branch_taken: pc_plus4 + (sign_extend(branch_imm)<<2), modulo 2^32.
  4. Otherwise: pc_plus4.
- Simultaneous jump and branch_taken: jump wins. Simultaneous jump_reg and jump: jump_reg wins.
- Arithmetic wraps: pc=32'hFFFF_FFFC gives pc_plus4=0, and the next sequential fetch is at 0.
- pc_plus4 is combinational from pc.
- misalign_err clears only on reset.

Decomposition:
- Shared package/header (mips.h): RESET_PC default, FSM state encodings (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2), NOP constant 32'h0.
- One natural sub-module: next_pc_sel. It is combinational priority mux plus branch/jump target arithmetic, with inputs pc_plus4, redirect bits, immediates and jr_target.
- The FSM, PC register and counters stay in fetch_unit.

Test Plan:
- Reset, memory responds 2 cycles after req with 32'h2008_0005 → imem_addr=32'h0040_0000; instr_valid rises one cycle after rvalid; instr=32'h2008_0005; fetch_count=1.
- Sequential: three advances with no redirects → fetch addresses 0x00400004, 0x00400008, 0x0040000C; instr=0 between fetches.
- Branch: pc=0x00400010, branch_taken=1, branch_imm=16'hFFFE on advance → next fetch at 0x0040000C. Same with jump=1 and jump_index=26'h0100040 → next fetch at 0x00400100 (jump wins).
- JR: jr_target=0x00400203 with jump_reg=1 and jump=1 → fetch at 0x00400200; misalign_err=1 and remains set.
- Robustness: advance pulsed in WAIT and rvalid pulsed in HOLD → no PC change, no extra fetch_count increment.
- Wrap and reset: pc=0xFFFFFFFC sequential advance → fetch at 0. Assert rst_n=0 in WAIT → next edge pc=RESET_PC, imem_req=0, instr_valid=0, misalign_err=0.
